// File: rtl/cordic_skid_buffer.sv
// cordic_skid_buffer: two-entry valid/ready register stage for the CORDIC
// pipeline. It behaves like a plain pipeline flop, honours downstream
// backpressure, and keeps in_ready registered so that no combinational ready
// path runs upstream.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   producer has a word on in_data
//   in_ready   buffer can accept a word this cycle (registered)
//   in_data    producer payload (WIDTH bits)
//   out_valid  out_data holds a valid word (registered)
//   out_ready  consumer takes out_data this cycle
//   out_data   payload presented to the consumer (registered, main register)
//   occupancy  number of words held: 0, 1 or 2 (registered, equals state)
module cordic_skid_buffer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  localparam int unsigned OCC_W = 2;

  // The state encoding is the occupancy count itself.
  localparam logic [OCC_W-1:0] EMPTY = 2'd0;
  localparam logic [OCC_W-1:0] ONE   = 2'd1;
  localparam logic [OCC_W-1:0] FULL  = 2'd2;

  logic [OCC_W-1:0] state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer  = in_valid  & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  // Next-state and next-data selection.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_d  = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = in_data;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end else if (in_xfer) begin
          // Consumer stalled: park the new word behind the one on out_data.
          skid_d  = in_data;
          state_d = FULL;
        end
      end
      FULL: begin
        // in_ready is low here, so only the consumer side can move.
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State, storage and handshake registers. Ready/valid are computed from the
  // next state so they line up with the registered data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = state_q;

endmodule

// File: tb/tb_cordic_skid_buffer.sv
// Testbench for cordic_skid_buffer: directed scenarios followed by random
// traffic, all checked against a queue-based FIFO reference model.
module tb_cordic_skid_buffer;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model: words held, oldest first, plus the registered ready.
  logic [WIDTH-1:0] q[$];
  logic             m_rdy = 1'b0;

  always #5 clk = ~clk;

  cordic_skid_buffer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".in_ready"},  32'(in_ready),  32'(m_rdy));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    check({tag, ".occupancy"}, 32'(occupancy), 32'(q.size()));
    if (q.size() != 0)
      check({tag, ".out_data"}, out_data, q[0]);
  endtask

  // One clock cycle: drive inputs (called from the falling edge), let the
  // model decide which transfers happen, then compare 1 time unit after the edge.
  task automatic cycle(input logic iv, input logic [WIDTH-1:0] id,
                       input logic ordy, input string tag);
    bit in_x;
    bit out_x;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    in_x  = iv && m_rdy;
    out_x = (q.size() != 0) && ordy;
    @(posedge clk);
    if (out_x) void'(q.pop_front());
    if (in_x)  q.push_back(id);
    m_rdy = (q.size() < 2);
    #1 check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    check_outputs(tag);
    check({tag, ".out_data_zero"}, out_data, 32'h0);
  endtask

  // Synchronous-looking reset sequence with in_valid held high throughout.
  task automatic apply_reset(input int n);
    @(negedge clk);
    reset_n   = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEAD_BEEF;
    out_ready = 1'b1;
    q.delete();
    m_rdy = 1'b0;
    #1 reset_checks("rst_async");
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 reset_checks("rst_hold");
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    apply_reset(3);
    // Release edge: in_valid still high, but nothing may be accepted.
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0, "release");
    check("release.in_ready_up", 32'(in_ready), 32'h1);

    // Streaming with the consumer always ready.
    cycle(1'b0, 32'h0, 1'b1, "idle");
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 32'(i), 1'b1, "stream");
      check("stream.word", out_data, 32'(i));
    end
    cycle(1'b0, 32'h0, 1'b1, "stream_tail");

    // Backpressure fill, rejected third word, then drain.
    cycle(1'b1, 32'hAAAA, 1'b0, "fill1");
    cycle(1'b1, 32'h5555, 1'b0, "fill2");
    check("fill2.full", 32'(occupancy), 32'h2);
    cycle(1'b1, 32'h1234, 1'b0, "fill3_blocked");
    check("fill3.hold", out_data, 32'hAAAA);
    cycle(1'b1, 32'h1234, 1'b1, "drain1");
    check("drain1.data", out_data, 32'h5555);
    cycle(1'b1, 32'h1234, 1'b1, "drain2");
    check("drain2.data", out_data, 32'h1234);
    cycle(1'b0, 32'h0, 1'b1, "drain3");

    // Simultaneous push and pop while holding one word.
    cycle(1'b1, 32'h0F0F, 1'b0, "pp_load");
    cycle(1'b1, 32'h7777, 1'b1, "pp");
    check("pp.data", out_data, 32'h7777);
    check("pp.occ", 32'(occupancy), 32'h1);
    cycle(1'b0, 32'h0, 1'b1, "pp_drain");

    // Asynchronous reset while full, asserted between clock edges.
    cycle(1'b1, 32'hCAFE, 1'b0, "ar_fill1");
    cycle(1'b1, 32'hF00D, 1'b0, "ar_fill2");
    #2 reset_n = 1'b0;
    q.delete();
    m_rdy = 1'b0;
    #1 reset_checks("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1'b0, 32'h0, 1'b1, "ar_release");
    cycle(1'b0, 32'h0, 1'b1, "ar_after");

    // Random traffic with phases of heavy and light backpressure.
    for (int i = 0; i < 3000; i++) begin
      logic iv;
      logic ordy;
      if ((i / 200) % 2 == 0)
        ordy = ($urandom_range(0, 3) != 0);
      else
        ordy = ($urandom_range(0, 3) == 0);
      iv = ($urandom_range(0, 2) != 0);
      cycle(iv, $urandom, ordy, "rand");
      if (i == 1500) begin
        apply_reset(2);
        cycle(1'b1, $urandom, 1'b1, "rand_release");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
